// File: rtl/dbg_apb_pkg.sv
// dbg_apb_pkg: shared state encoding, response codes and sizing helper for the debug APB master
package dbg_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    // Width of an index field able to address n items, never narrower than one bit
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_rr_arbiter.sv
// dbg_rr_arbiter: combinational round-robin pick, searching upward from the slot after ptr
module dbg_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    // First requester at or after ptr+1, wrapping, gets the one-hot grant
    always_comb begin
        int   k;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end

endmodule

// File: rtl/dbg_apb_master_arb.sv
// dbg_apb_master_arb: shares the debug APB bus among several requesters with round-robin arbitration
module dbg_apb_master_arb
    import dbg_apb_pkg::*;
#(
    parameter int NR_REQ         = 2,
    parameter int NR_SLAVES      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SLV_SEL_LSB    = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NR_REQ-1:0]                    req_valid,
    output logic [NR_REQ-1:0]                    req_ready,
    input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
    input  logic [NR_REQ-1:0]                    req_wr,
    input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
    input  logic [NR_REQ-1:0][3:0]               req_wstrb,
    output logic [NR_REQ-1:0]                    rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 rsp_err,
    output logic [ADDR_WIDTH-1:0]                paddr,
    output logic [NR_SLAVES-1:0]                 psel,
    output logic                                 penable,
    output logic                                 pwrite,
    output logic [DATA_WIDTH-1:0]                pwdata,
    output logic [3:0]                           pstrb,
    input  logic                                 pready,
    input  logic [DATA_WIDTH-1:0]                prdata
);

    localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int SW = sel_w(NR_SLAVES);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYCLES);

    state_t                  r_state;
    logic [PW-1:0]           r_ptr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_wr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_wstrb;
    logic [SW-1:0]           r_sel;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic [NR_REQ-1:0]       w_gnt;
    logic [PW-1:0]           w_gidx;
    logic [ADDR_WIDTH-1:0]   w_hi;
    logic                    w_dec_err;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_timeout;
    logic                    w_active;

    dbg_rr_arbiter #(.N(NR_REQ), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_gidx)
    );

    // Decode uses every address bit above the select LSB, so addresses beyond the last slave fault
    always_comb begin
        w_hi      = req_addr[w_gidx] >> SLV_SEL_LSB;
        w_dec_err = w_hi >= ADDR_WIDTH'(NR_SLAVES);
        w_cnt_nxt = r_cnt + 1'b1;
        w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == TO);
        w_active  = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    end

    // Bus and response outputs decode straight from state so an async reset drops them at once
    always_comb begin
        req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
        psel      = w_active ? (NR_SLAVES'(1) << r_sel) : '0;
        penable   = r_state == ST_ACCESS;
        paddr     = w_active ? r_addr : '0;
        pwrite    = w_active & r_wr;
        pwdata    = w_active ? r_wdata : '0;
        pstrb     = w_active ? r_wstrb : '0;
        rsp_valid = (r_state == ST_RESP) ? (NR_REQ'(1) << r_ptr) : '0;
        rsp_rdata = (r_state == ST_RESP) ? r_rdata : '0;
        rsp_err   = (r_state == ST_RESP) & r_err;
    end

    // Transfer sequencer: grant and latch, SETUP, ACCESS with timeout, one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(NR_REQ - 1);
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= RSP_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_ptr   <= w_gidx;
                        r_addr  <= req_addr[w_gidx];
                        r_wr    <= req_wr[w_gidx];
                        r_wdata <= req_wdata[w_gidx];
                        r_wstrb <= req_wstrb[w_gidx];
                        r_sel   <= w_hi[SW-1:0];
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        r_err   <= w_dec_err ? RSP_ERR : RSP_OK;
                        r_state <= w_dec_err ? ST_RESP : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rdata <= r_wr ? '0 : prdata;
                        r_err   <= RSP_OK;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= RSP_ERR;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt   <= w_cnt_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_apb_master_arb.sv
// tb_dbg_apb_master_arb: directed vector table plus corner-case sequences for the debug APB master
module tb_dbg_apb_master_arb;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0]        req_wr = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0][3:0]   req_wstrb = '0;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       paddr;
    logic [3:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic              pready = 1'b0;
    logic [31:0]       prdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    dbg_apb_master_arb #(
        .NR_REQ(2), .NR_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLV_SEL_LSB(12), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] prd;
        logic [3:0]  exp_psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    function automatic logic [1:0] oh(input int r);
        logic [1:0] v;
        v = 2'b01 << r;
        return v;
    endfunction

    // One complete transfer from a single requester, checked cycle by cycle
    task automatic apply_vec(input vec_t v);
        nxt();
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        req_addr[v.r] = v.addr;
        req_wr[v.r] = v.wr;
        req_wdata[v.r] = v.wdata;
        req_wstrb[v.r] = v.wstrb;
        pready = 1'b0;
        mid();
        chk("req_ready", req_ready, oh(v.r));
        nxt();
        req_valid = '0;
        mid();
        if (v.exp_err) begin
            chk("dec_psel", psel, 4'b0000);
            chk("dec_rsp_valid", rsp_valid, oh(v.r));
            chk("dec_rsp_err", rsp_err, 1'b1);
            chk("dec_rdata", rsp_rdata, 32'h0);
        end else begin
            chk("setup_psel", psel, v.exp_psel);
            chk("setup_penable", penable, 1'b0);
            chk("setup_paddr", paddr, v.addr);
            chk("setup_pwrite", pwrite, v.wr);
            for (int w = 0; w <= v.waits; w++) begin
                nxt();
                pready = (w == v.waits);
                prdata = v.prd;
                mid();
                chk("acc_penable", penable, 1'b1);
                chk("acc_psel", psel, v.exp_psel);
                chk("acc_pwdata", pwdata, v.wdata);
                chk("acc_pstrb", pstrb, v.wstrb);
                chk("acc_no_rsp", rsp_valid, 2'b00);
            end
            nxt();
            pready = 1'b0;
            mid();
            chk("rsp_valid", rsp_valid, oh(v.r));
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_err", rsp_err, 1'b0);
            chk("rsp_psel_low", psel, 4'b0000);
        end
        nxt();
        mid();
        chk("rsp_one_cycle", rsp_valid, 2'b00);
    endtask

    initial begin
        int exp_g;
        int got;
        int pen;

        vecs[0] = '{0, 32'h0000_1004, 1'b0, 32'h0,         4'hF,    0, 32'hDEAD_BEEF, 4'b0010, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h0000_3008, 1'b1, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, 4'b1000, 1'b0, 32'h0};
        vecs[2] = '{0, 32'h0000_5000, 1'b0, 32'h0,         4'hF,    0, 32'h0,         4'b0000, 1'b1, 32'h0};
        vecs[3] = '{1, 32'h0000_0010, 1'b0, 32'h0,         4'hF,    1, 32'hA5A5_0001, 4'b0001, 1'b0, 32'hA5A5_0001};
        vecs[4] = '{0, 32'h0000_2FFC, 1'b1, 32'hCAFE_F00D, 4'b1100, 0, 32'h5555_5555, 4'b0100, 1'b0, 32'h0};

        // reset state
        nxt();
        mid();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_psel", psel, 4'b0000);
        chk("rst_penable", penable, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        nxt();
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

        // both requesters held: last grant was requester 0, so 1,0,1,0
        nxt();
        req_valid = 2'b11;
        req_addr[0] = 32'h0000_1000;
        req_addr[1] = 32'h0000_1000;
        req_wr = 2'b00;
        pready = 1'b1;
        prdata = 32'h0BAD_CAFE;
        exp_g = 1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            mid();
            if (req_ready != 2'b00) begin
                chk("rr_grant", req_ready, oh(exp_g));
                exp_g ^= 1;
                got++;
            end
            nxt();
        end
        chk("rr_count", got, 4);
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) nxt();
        pready = 1'b0;

        // ready timeout: penable for exactly 8 cycles, then error response
        req_valid = 2'b01;
        req_addr[0] = 32'h0000_1000;
        req_wr[0] = 1'b0;
        mid();
        chk("to_req_ready", req_ready, 2'b01);
        nxt();
        req_valid = 2'b00;
        mid();
        chk("to_setup_psel", psel, 4'b0010);
        pen = 0;
        for (int c = 0; c < 20; c++) begin
            nxt();
            mid();
            if (!penable) break;
            pen++;
        end
        chk("to_penable_cycles", pen, 8);
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        chk("to_psel_low", psel, 4'b0000);
        apply_vec(vecs[0]);

        // async reset during ACCESS
        nxt();
        req_valid = 2'b01;
        req_addr[0] = 32'h0000_1000;
        req_wr[0] = 1'b0;
        pready = 1'b0;
        nxt();
        req_valid = 2'b00;
        nxt();
        mid();
        chk("ar_penable_before", penable, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_psel_async", psel, 4'b0000);
        chk("ar_penable_async", penable, 1'b0);
        for (int c = 0; c < 2; c++) begin
            nxt();
            mid();
            chk("ar_no_rsp", rsp_valid, 2'b00);
        end
        nxt();
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_addr[0] = 32'h0000_2000;
        req_addr[1] = 32'h0000_1000;
        req_wr = 2'b00;
        prdata = 32'h7777_1234;
        mid();
        chk("ar_first_grant", req_ready, 2'b01);
        nxt();
        req_valid = 2'b00;
        mid();
        chk("ar_psel", psel, 4'b0100);
        nxt();
        pready = 1'b1;
        nxt();
        pready = 1'b0;
        mid();
        chk("ar_rsp_valid", rsp_valid, 2'b01);
        chk("ar_rsp_rdata", rsp_rdata, 32'h7777_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
